arb_mux_reg: RTL and testbench
==============================

Name: arb_mux_reg

Overview:
- Parametrised successor to the team's fixed 6-way, 32-bit select mux.
- Selects one of N_CH data channels and delivers it through a registered output stage with valid/ready handshakes on every channel and on the output.
- Three selection modes: direct select, fixed priority, and round-robin.
- Sits in the datapath wherever several producers (ALU, memory data register, PC sources, shifter) feed one consumer register.

Parameters:
- WIDTH, 32: data width per channel.
- N_CH, 6: number of input channels, minimum 2.
- MODE, MODE_SEL: selection policy, type mode_e. MODE_SEL uses the sel port; MODE_FIXED grants the lowest index; MODE_RR rotates.
- SEL_W, $clog2(N_CH): derived localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  N_CH x WIDTH  packed array of channel data.
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready; one-hot or zero.
- sel  in  SEL_W  channel select; used only in MODE_SEL.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data holds an untaken word.
- out_ready  in  1  consumer accepts out_data.
- out_sel  out  SEL_W  index of the channel that produced out_data.
- sel_err  out  1  registered with the word; sel was out of range when that word was accepted.

Behaviour:
- Reset: asynchronous clear on reset_n=0.
  - out_valid=0, out_data=0, out_sel=0, sel_err=0.
  - Round-robin pointer=N_CH-1, so the first search starts at channel 0.
  - Any held word is dropped. in_ready=0 while reset_n=0.
- Accept condition: accept = !out_valid || out_ready (combinational).
- Grant selection, combinational, one-hot grant over channels:
  - MODE_SEL: grant channel sel.
    - If sel >= N_CH, grant channel 0 (legacy default) and flag err_next=1.
    - Grant is independent of in_valid: in_ready[sel] can be 1 while that channel is idle.
  - MODE_FIXED: lowest-index channel with in_valid=1. No valid channel means no grant.
  - MODE_RR: first valid channel searching from ptr+1 upward, wrapping N_CH-1 -> 0. No valid channel means no grant.
- in_ready[i] = accept && grant[i]. No combinational path from in_valid to in_ready in MODE_SEL.
- Transfer: in_valid[g] && in_ready[g] at a rising edge.
  - Next cycle: out_data=in_data[g], out_sel=g, sel_err=err_next (always 0 outside MODE_SEL), out_valid=1.
  - Latency is 1 cycle.
- Output completes when out_valid && out_ready. If no transfer occurs in that same cycle, out_valid goes to 0.
  - Simultaneous drain and refill gives back-to-back words with out_valid held at 1.
  - Throughput is 1 word/cycle.
- Stall: while out_valid && !out_ready, out_data, out_sel and sel_err hold stable and every in_ready is 0.
- Round-robin pointer updates to g only on a transfer. Stalls and idle cycles leave it unchanged.
- Mode is static. sel changes take effect on the next grant evaluation; there is no sel latch.
- Width rules:
  - Data passes unmodified, with no extension or truncation.
  - SEL_W comparisons are unsigned.
  - For N_CH a power of two, sel_err can never assert.

Decomposition:
- Package arb_mux_pkg holds:
  - typedef enum logic [1:0] mode_e {MODE_SEL, MODE_FIXED, MODE_RR}.
  - Function first_from(valid, start) returning the index and a found bit; shared by the FIXED (start=0) and RR paths.
- One sub-module, rr_arbiter, parameterised by N_CH.
  - Contains the pointer register and the wrap search.
  - Outputs a one-hot grant; inputs are in_valid and advance.
  - Instantiated only when MODE==MODE_RR, via a generate block.

Test Plan:
1. MODE_SEL, N_CH=6, WIDTH=32, out_ready=1.
   - Stimulus: in_data[i]=32'h1000_0000+i, all valid; sel steps 0..5 on consecutive cycles.
   - Required: out_data 32'h1000_0000..32'h1000_0005, one per cycle, each 1 cycle after its sel; out_sel 0..5; sel_err=0.
2. MODE_SEL with sel=3'b110 and sel=3'b111.
   - Required: in_ready[0]=1; out_data=in_data[0]; out_sel=0; sel_err=1 with that word only.
3. Backpressure.
   - Stimulus: accept a word 32'hDEAD_BEEF; hold out_ready=0 for 4 cycles.
   - Required: out_valid=1 and out_data stable throughout; all in_ready=0. When out_ready=1, next word appears the following cycle with no bubble.
4. MODE_RR, N_CH=4, all four channels valid continuously, out_ready=1.
   - Required: grants 0,1,2,3,0,1 in order.
   - Then drop in_valid[1]: required sequence 2,3,0,2.
   - Stall for 3 cycles: pointer unchanged.
5. MODE_FIXED.
   - Stimulus: in_valid=4'b1010.
   - Required: channel 1 granted repeatedly; channel 3 starves until in_valid[1]=0, then channel 3 is granted the next cycle.
6. Reset mid-operation.
   - Stimulus: assert reset_n=0 asynchronously between edges with out_valid=1 and the round-robin pointer at 2.
   - Required: out_valid, out_data, out_sel and sel_err go to 0 immediately. After release, the first round-robin grant is channel 0.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared types and search helper for the arbitrated, registered channel mux.
package arb_mux_pkg;

  typedef enum logic [1:0] {
    MODE_SEL,
    MODE_FIXED,
    MODE_RR
  } mode_e;

  // Upper bound on channel count that first_from can search.
  localparam int unsigned MaxCh   = 64;
  localparam int unsigned MaxIdxW = 6;

  typedef struct packed {
    logic               found;
    logic [MaxIdxW-1:0] idx;
  } first_t;

  // First set bit of valid, scanning upward from start and wrapping at n_ch.
  function automatic first_t first_from(input logic [MaxCh-1:0] valid,
                                        input int unsigned      start,
                                        input int unsigned      n_ch);
    first_t      res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MaxCh; k++) begin
      idx = start + k;
      if (idx >= n_ch) idx = idx - n_ch;
      if ((k < n_ch) && !res.found && valid[idx[MaxIdxW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[MaxIdxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus wrapping search from pointer + 1.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned N_CH = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] in_valid,
  input  logic            advance,
  output logic [N_CH-1:0] grant
);

  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [MaxCh-1:0] valid_ext;
  int unsigned      start;
  first_t           pick;
  logic             unused_pick;

  always_comb begin
    valid_ext               = '0;
    valid_ext[N_CH-1:0]     = in_valid;
    start                   = (32'(ptr_q) + 1 >= N_CH) ? 0 : 32'(ptr_q) + 1;
    pick                    = first_from(valid_ext, start, N_CH);
    grant                   = '0;
    if (pick.found) grant[pick.idx[SEL_W-1:0]] = 1'b1;
    // A found grant with advance asserted is always a completed transfer.
    ptr_d = (advance && pick.found) ? pick.idx[SEL_W-1:0] : ptr_q;
  end

  assign unused_pick = ^pick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= SEL_W'(N_CH - 1);
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/arb_mux_reg.sv
// N-way channel mux with select/fixed/round-robin grant and a registered
// valid/ready output stage.
module arb_mux_reg
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_CH  = 6,
  parameter mode_e       MODE  = MODE_SEL
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_CH-1:0][WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]            in_valid,
  output logic [N_CH-1:0]            in_ready,
  input  logic [$clog2(N_CH)-1:0]    sel,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_CH)-1:0]    out_sel,
  output logic                       sel_err
);

  localparam int unsigned SEL_W = $clog2(N_CH);

  logic             accept;
  logic [N_CH-1:0]  grant;
  logic             err_next;
  logic [SEL_W-1:0] gidx;
  logic             xfer;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] osel_q, osel_d;
  logic             err_q, err_d;

  assign accept = !valid_q || out_ready;

  if (MODE == MODE_RR) begin : g_rr
    logic unused_rr;
    rr_arbiter #(.N_CH(N_CH)) u_rr (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .advance  (accept),
      .grant    (grant)
    );
    assign err_next  = 1'b0;
    assign unused_rr = ^sel;
  end else if (MODE == MODE_FIXED) begin : g_fixed
    first_t           pick;
    logic [MaxCh-1:0] valid_ext;
    logic             unused_fixed;
    always_comb begin
      valid_ext           = '0;
      valid_ext[N_CH-1:0] = in_valid;
      pick                = first_from(valid_ext, 0, N_CH);
      grant               = '0;
      if (pick.found) grant[pick.idx[SEL_W-1:0]] = 1'b1;
    end
    assign err_next     = 1'b0;
    assign unused_fixed = ^{pick, sel};
  end else begin : g_sel
    // Grant follows sel regardless of in_valid; out-of-range falls back to channel 0.
    always_comb begin
      grant    = '0;
      err_next = 1'b0;
      if (32'(sel) >= N_CH) begin
        grant[0] = 1'b1;
        err_next = 1'b1;
      end else begin
        grant[sel] = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) gidx = SEL_W'(i);
    end
  end

  assign in_ready = (reset_n && accept) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    osel_d  = osel_q;
    err_d   = err_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = in_data[gidx];
      osel_d  = gidx;
      err_d   = err_next;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      osel_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      osel_q  <= osel_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = osel_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: three instances (select N=6, round-robin N=4, fixed N=4)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_arb_mux_reg;
  import arb_mux_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Instance 0: MODE_SEL, N_CH=6
  logic [5:0][31:0] s_data;
  logic [5:0]       s_valid, s_ready;
  logic [2:0]       s_sel, s_osel;
  logic [31:0]      s_dout;
  logic             s_vout, s_ordy, s_err;
  // Instance 1: MODE_RR, N_CH=4
  logic [3:0][31:0] r_data;
  logic [3:0]       r_valid, r_ready;
  logic [1:0]       r_sel, r_osel;
  logic [31:0]      r_dout;
  logic             r_vout, r_ordy, r_err;
  // Instance 2: MODE_FIXED, N_CH=4
  logic [3:0][31:0] f_data;
  logic [3:0]       f_valid, f_ready;
  logic [1:0]       f_sel, f_osel;
  logic [31:0]      f_dout;
  logic             f_vout, f_ordy, f_err;

  arb_mux_reg #(.WIDTH(32), .N_CH(6), .MODE(MODE_SEL)) u_sel (
    .clk(clk), .reset_n(reset_n), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
    .sel(s_sel), .out_data(s_dout), .out_valid(s_vout), .out_ready(s_ordy), .out_sel(s_osel),
    .sel_err(s_err)
  );
  arb_mux_reg #(.WIDTH(32), .N_CH(4), .MODE(MODE_RR)) u_rr (
    .clk(clk), .reset_n(reset_n), .in_data(r_data), .in_valid(r_valid), .in_ready(r_ready),
    .sel(r_sel), .out_data(r_dout), .out_valid(r_vout), .out_ready(r_ordy), .out_sel(r_osel),
    .sel_err(r_err)
  );
  arb_mux_reg #(.WIDTH(32), .N_CH(4), .MODE(MODE_FIXED)) u_fix (
    .clk(clk), .reset_n(reset_n), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
    .sel(f_sel), .out_data(f_dout), .out_valid(f_vout), .out_ready(f_ordy), .out_sel(f_osel),
    .sel_err(f_err)
  );

  // Uniform views of each instance's signals.
  function automatic int nch(input int d); return (d == 0) ? 6 : 4; endfunction
  function automatic logic [5:0] vin(input int d);
    case (d)
      0:       return s_valid;
      1:       return {2'b00, r_valid};
      default: return {2'b00, f_valid};
    endcase
  endfunction
  function automatic logic [31:0] din(input int d, input int ch);
    case (d)
      0:       return s_data[ch[2:0]];
      1:       return r_data[ch[1:0]];
      default: return f_data[ch[1:0]];
    endcase
  endfunction
  function automatic bit ordy(input int d);
    return (d == 0) ? s_ordy : (d == 1) ? r_ordy : f_ordy;
  endfunction
  function automatic logic [31:0] a_ready(input int d);
    return (d == 0) ? 32'(s_ready) : (d == 1) ? 32'(r_ready) : 32'(f_ready);
  endfunction
  function automatic logic [31:0] a_dout(input int d);
    return (d == 0) ? s_dout : (d == 1) ? r_dout : f_dout;
  endfunction
  function automatic logic [31:0] a_osel(input int d);
    return (d == 0) ? 32'(s_osel) : (d == 1) ? 32'(r_osel) : 32'(f_osel);
  endfunction
  function automatic logic a_vout(input int d);
    return (d == 0) ? s_vout : (d == 1) ? r_vout : f_vout;
  endfunction
  function automatic logic a_err(input int d);
    return (d == 0) ? s_err : (d == 1) ? r_err : f_err;
  endfunction

  // Chosen channel by the policy rules, or -1 when nothing is granted.
  function automatic int pick(input int d, input int ptr);
    int         n;
    int         c;
    logic [5:0] v;
    n = nch(d);
    v = vin(d);
    if (d == 0) return (int'(s_sel) >= n) ? 0 : int'(s_sel);
    for (int k = 1; k <= n; k++) begin
      c = (d == 1) ? (ptr + k) % n : k - 1;
      if (v[c[2:0]]) return c;
    end
    return -1;
  endfunction

  // Model state
  logic        m_valid [3];
  logic [31:0] m_data  [3];
  int          m_sel   [3];
  logic        m_err   [3];
  int          m_ptr   [3];
  int          e_g     [3];
  logic [31:0] e_ready [3];
  bit          e_xfer  [3];

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      e_g[d]     = pick(d, m_ptr[d]);
      e_ready[d] = '0;
      if (reset_n && (!m_valid[d] || ordy(d)) && (e_g[d] >= 0)) e_ready[d] = 32'd1 << e_g[d];
      e_xfer[d]  = (e_ready[d] & 32'(vin(d))) != 0;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 3; d++) begin
        m_valid[d] <= 1'b0;
        m_data[d]  <= '0;
        m_sel[d]   <= 0;
        m_err[d]   <= 1'b0;
        m_ptr[d]   <= nch(d) - 1;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (e_xfer[d]) begin
          m_valid[d] <= 1'b1;
          m_data[d]  <= din(d, e_g[d]);
          m_sel[d]   <= e_g[d];
          m_err[d]   <= (d == 0) && (int'(s_sel) >= 6);
          if (d == 1) m_ptr[d] <= e_g[d];
        end else if (ordy(d)) begin
          m_valid[d] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("m%0d_ready", d), a_ready(d), e_ready[d]);
        chk($sformatf("m%0d_valid", d), 32'(a_vout(d)), 32'(m_valid[d]));
        chk($sformatf("m%0d_data", d), a_dout(d), m_data[d]);
        chk($sformatf("m%0d_sel", d), a_osel(d), 32'(m_sel[d]));
        chk($sformatf("m%0d_err", d), 32'(a_err(d)), 32'(m_err[d]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_a[6] = '{0, 1, 2, 3, 0, 1};
  int rr_b[4] = '{2, 3, 0, 2};

  initial begin
    for (int i = 0; i < 6; i++) s_data[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 4; i++) r_data[i] = 32'h2000_0000 + 32'(i);
    for (int i = 0; i < 4; i++) f_data[i] = 32'h3000_0000 + 32'(i);
    s_valid = '0; r_valid = '0; f_valid = '0;
    s_sel = '0; r_sel = '0; f_sel = '0;
    s_ordy = 1'b1; r_ordy = 1'b1; f_ordy = 1'b1;

    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_valid", 32'(s_vout), 32'd0);
    chk("rst_data", s_dout, 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    tick();
    reset_n = 1'b1;

    // Direct select walk
    s_valid = 6'h3f;
    for (int i = 0; i < 6; i++) begin
      s_sel = 3'(i);
      tick();
      chk("t1_data", s_dout, 32'h1000_0000 + 32'(i));
      chk("t1_sel", 32'(s_osel), 32'(i));
      chk("t1_err", 32'(s_err), 32'd0);
      chk("t1_valid", 32'(s_vout), 32'd1);
    end

    // Out-of-range selects
    s_sel = 3'd6;
    #1 chk("t2_ready6", 32'(s_ready), 32'h01);
    tick();
    chk("t2_data6", s_dout, 32'h1000_0000);
    chk("t2_sel6", 32'(s_osel), 32'd0);
    chk("t2_err6", 32'(s_err), 32'd1);
    s_sel = 3'd7;
    #1 chk("t2_ready7", 32'(s_ready), 32'h01);
    tick();
    chk("t2_err7", 32'(s_err), 32'd1);
    s_sel = 3'd2;
    tick();
    chk("t2_err_clr", 32'(s_err), 32'd0);
    chk("t2_data2", s_dout, 32'h1000_0002);

    // Backpressure
    s_data[4] = 32'hDEAD_BEEF;
    s_sel = 3'd4;
    tick();
    chk("t3_word", s_dout, 32'hDEAD_BEEF);
    s_ordy = 1'b0;
    s_sel = 3'd5;
    #1 chk("t3_ready0", 32'(s_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hold_valid", 32'(s_vout), 32'd1);
      chk("t3_hold_data", s_dout, 32'hDEAD_BEEF);
      chk("t3_hold_ready", 32'(s_ready), 32'd0);
    end
    s_ordy = 1'b1;
    #1 chk("t3_ready5", 32'(s_ready), 32'h20);
    tick();
    chk("t3_next_data", s_dout, 32'h1000_0005);
    chk("t3_next_valid", 32'(s_vout), 32'd1);
    s_valid = '0;
    tick();
    chk("t3_drained", 32'(s_vout), 32'd0);

    // Fixed priority starvation
    f_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_sel1", 32'(f_osel), 32'd1);
    end
    f_valid = 4'b1000;
    tick();
    chk("t5_sel3", 32'(f_osel), 32'd3);
    chk("t5_data3", f_dout, 32'h3000_0003);
    f_valid = '0;
    tick();

    // Round-robin rotation
    r_valid = 4'hf;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_rr_a", 32'(r_osel), 32'(rr_a[k]));
    end
    r_valid = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_rr_b", 32'(r_osel), 32'(rr_b[k]));
    end
    chk("t4_data2", r_dout, 32'h2000_0002);
    r_ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_sel", 32'(r_osel), 32'd2);
      chk("t4_stall_ready", 32'(r_ready), 32'd0);
    end
    r_ordy = 1'b1;
    tick();
    chk("t4_after_stall", 32'(r_osel), 32'd3);
    tick();
    chk("t4_rr_c0", 32'(r_osel), 32'd0);
    tick();
    chk("t4_rr_c2", 32'(r_osel), 32'd2);

    // Asynchronous reset with pointer at 2 and a word held
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid", 32'(r_vout), 32'd0);
    chk("t6_data", r_dout, 32'd0);
    chk("t6_sel", 32'(r_osel), 32'd0);
    chk("t6_err", 32'(r_err), 32'd0);
    chk("t6_ready", 32'(r_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_first", 32'(r_osel), 32'd0);
    chk("t6_first_data", r_dout, 32'h2000_0000);
    tick();
    chk("t6_second", 32'(r_osel), 32'd2);
    r_valid = '0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
